// File: rtl/vpcie_pkg.sv
// Shared types for the virtual PCIe message queue: FSM state encoding and the
// header entry that is buffered per message.
package vpcie_pkg;

   // Widest address/payload a header entry can carry; narrower ports zero-extend.
   localparam int unsigned MSG_ADDR_W = 64;
   localparam int unsigned MSG_DATA_W = 64;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StFlush  = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0]            op;
      logic [7:0]            bar;
      logic [7:0]            width;
      logic [MSG_ADDR_W-1:0] addr;
      logic [15:0]           size;
      logic [MSG_DATA_W-1:0] data;
   } msg_hdr_t;

   localparam int unsigned MSG_HDR_W = $bits(msg_hdr_t);

endpackage

// File: rtl/vpcie_sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous clear and occupancy.
// A push while full is accepted only if a pop happens in the same cycle.
module vpcie_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == LW'(DEPTH));
   assign level   = cnt_q;
   assign rdata   = mem[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + LW'(1);
            2'b01:   cnt_q <= cnt_q - LW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/vpcie_msg_queue.sv
// Buffers simulator-side PCIe request headers, routes the head entry to the
// channel selected by its BAR, and returns credits for consumed entries.
module vpcie_msg_queue
   import vpcie_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      connected,
   input  logic                      new_msg,
   input  logic [7:0]                op,
   input  logic [7:0]                bar,
   input  logic [7:0]                width,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [15:0]               size,
   input  logic [DATA_W-1:0]         word_data,
   output logic [NUM_CH-1:0]         out_valid,
   input  logic [NUM_CH-1:0]         out_ready,
   output logic [7:0]                out_op,
   output logic [7:0]                out_width,
   output logic [ADDR_W-1:0]         out_addr,
   output logic [15:0]               out_size,
   output logic [DATA_W-1:0]         out_data,
   output logic                      credit_token,
   output logic                      running,
   output logic                      overflow,
   output logic                      bad_bar,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned CW = LW + 1;

   state_e               state_q, state_d;
   msg_hdr_t             hdr_in, head;
   logic [MSG_HDR_W-1:0] fifo_rdata;
   logic                 fifo_full, fifo_empty;
   logic [LW-1:0]        fifo_level;
   logic                 active, flush;
   logic                 head_bar_ok, discard, pop, push_req, push_acc;
   logic [LW-1:0]        pending_q, pending_d;
   logic [CW-1:0]        lvl_nxt, sum, cap;
   logic                 overflow_q, bad_bar_q;

   assign active = (state_q == StActive);
   assign flush  = (state_q == StFlush);

   always_comb begin
      hdr_in       = '0;
      hdr_in.op    = op;
      hdr_in.bar   = bar;
      hdr_in.width = width;
      hdr_in.addr  = MSG_ADDR_W'(addr);
      hdr_in.size  = size;
      hdr_in.data  = MSG_DATA_W'(word_data);
   end

   vpcie_sync_fifo #(
      .WIDTH (MSG_HDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push_acc),
      .wdata (hdr_in),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign head        = msg_hdr_t'(fifo_rdata);
   assign head_bar_ok = (32'(head.bar) < NUM_CH);
   assign discard     = active & ~fifo_empty & ~head_bar_ok;

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         out_valid[i] = active & ~fifo_empty & head_bar_ok & (head.bar == 8'(i));
      end
   end

   assign pop      = (|(out_valid & out_ready)) | discard;
   assign push_req = active & new_msg;
   assign push_acc = push_req & (~fifo_full | pop);

   // Storage is not reset, so head fields are forced to zero when empty.
   assign out_op    = fifo_empty ? '0 : head.op;
   assign out_width = fifo_empty ? '0 : head.width;
   assign out_addr  = fifo_empty ? '0 : head.addr[ADDR_W-1:0];
   assign out_size  = fifo_empty ? '0 : head.size;
   assign out_data  = fifo_empty ? '0 : head.data[DATA_W-1:0];

   assign credit_token = active & (pending_q != '0);
   assign running      = active;
   assign overflow     = overflow_q;
   assign bad_bar      = bad_bar_q;
   assign level        = fifo_level;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (connected) state_d = StActive;
         StActive: if (!connected) state_d = StFlush;
         StFlush:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Credits are capped at the free slots left after this cycle, so a push that
   // reuses a slot freed in the same cycle consumes that slot's credit.
   always_comb begin
      lvl_nxt   = CW'(fifo_level) + CW'(push_acc) - CW'(pop);
      sum       = CW'(pending_q) + CW'(pop) - CW'(credit_token);
      cap       = CW'(DEPTH) - lvl_nxt;
      pending_d = pending_q;
      if (flush) begin
         pending_d = LW'(DEPTH);
      end else if (sum > cap) begin
         pending_d = LW'(cap);
      end else begin
         pending_d = LW'(sum);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pending_q  <= LW'(DEPTH);
         overflow_q <= 1'b0;
         bad_bar_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (flush) begin
            overflow_q <= 1'b0;
            bad_bar_q  <= 1'b0;
         end else begin
            if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
            if (discard) bad_bar_q <= 1'b1;
         end
      end
   end

endmodule

// File: doc/vpcie_msg_queue.md
VPCIE_MSG_QUEUE -- requirements
Module: vpcie_msg_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning header entries buffered (power of two, >=2).
REQ-002 SHALL have parameter NUM_CH, default 4, meaning BAR-indexed output channels (1..8).
REQ-003 SHALL have parameter ADDR_W, default 64, meaning address field width.
REQ-004 SHALL have parameter DATA_W, default 32, meaning word_data field width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- connected  in  1  simulator link up.
- new_msg  in  1  one-cycle push strobe.
- op  in  8  opcode.
- bar  in  8  target BAR index.
- width  in  8  access width.
- addr  in  ADDR_W  address.
- size  in  16  byte count.
- word_data  in  DATA_W  payload.
- out_valid  out  NUM_CH  one-hot head-valid per channel.
- out_ready  in  NUM_CH  per-channel accept.
- out_op / out_width  out  8  head fields.
- out_addr  out  ADDR_W  head field.
- out_size  out  16  head field.
- out_data  out  DATA_W  head field.
- credit_token  out  1  one-cycle credit return to simulator.
- running  out  1  FSM in ACTIVE.
- overflow  out  1  sticky, push while full.
- bad_bar  out  1  sticky, head bar >= NUM_CH.
- level  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-006 SHALL implement FSM states IDLE, ACTIVE, FLUSH.
- IDLE->ACTIVE when connected=1.
- ACTIVE->FLUSH when connected=0.
- FLUSH->IDLE after exactly one cycle.
REQ-007 SHALL accept pushes only in ACTIVE; new_msg in IDLE/FLUSH ignored, no flag.
REQ-008 SHALL store op,bar,width,addr,size,word_data in FIFO on accepted push; registered, entry visible at head the cycle after the push at earliest.
REQ-009 SHALL assert out_valid[bar] only (others 0) when non-empty, ACTIVE, and head bar < NUM_CH.
REQ-010 SHALL pop when out_valid[i] & out_ready[i]; out_ready bits of non-valid channels ignored.
REQ-011 SHALL discard a head with bar >= NUM_CH automatically in one cycle: out_valid all 0, sets bad_bar.
REQ-012 SHALL, on push while full with no same-cycle pop/discard, drop the push, set overflow; with same-cycle pop/discard, accept the push.
REQ-013 SHALL keep level = entries held; simultaneous push and pop leaves level unchanged; pointers wrap modulo DEPTH.
REQ-014 SHALL keep a credit_pending counter (width $clog2(DEPTH)+1):
- +1 per pop or discard.
- -1 per credit_token cycle.
- Both in the same cycle leaves it unchanged.
REQ-015 SHALL assert credit_token for one cycle whenever ACTIVE and credit_pending>0, at most one token per cycle.
REQ-016 SHALL never let credit_pending + level exceed DEPTH.
REQ-017 SHALL in FLUSH empty the FIFO, set credit_pending=DEPTH, and clear overflow and bad_bar; no tokens in FLUSH.
REQ-018 SHALL drive running=1 exactly in ACTIVE.

Reset
REQ-019 SHALL on rst (sampled at clk):
- FSM=IDLE.
- FIFO empty, level=0.
- credit_pending=DEPTH.
- out_valid=0, credit_token=0, running=0, overflow=0, bad_bar=0.
- out_* data fields=0.
REQ-020 SHALL give rst priority over all events; rst mid-operation discards contents without emitting tokens.

Structure
REQ-021 SHALL place state encoding (IDLE/ACTIVE/FLUSH) and the header entry struct type in shared package vpcie_pkg.
REQ-022 SHALL instantiate one sub-module vpcie_sync_fifo (parametrised width/depth, push/pop/full/empty/level) for storage; FSM, routing and credit logic in vpcie_msg_queue.

Verification
REQ-023 Reset then connected=1, DEPTH=8 -> exactly 8 credit_token pulses on 8 consecutive cycles, then low.
REQ-024 ACTIVE; push bar=2, addr=0x1000, size=4, out_ready=4'b0100 -> out_valid=4'b0100 next cycle, fields match, pop; one credit_token follows.
REQ-025 Push 8 entries, no ready, then push 9th -> level=8, overflow=1, 9th absent; push plus pop when full -> level stays 8, overflow unchanged.
REQ-026 Push bar=7 with NUM_CH=4 -> out_valid never asserts, bad_bar=1, entry discarded, one credit_token.
REQ-027 Push 3 entries, drop connected -> FLUSH one cycle, level=0, flags cleared, no tokens; reconnect -> 8 tokens again.
REQ-028 Assert rst with 5 entries and pending credits -> next cycle all outputs at reset values, no credit_token.
